// File: rtl/ex_unit.sv
// Execute stage: combinational ALU with HI/LO registers and a multi-cycle restoring divider.
// The divider and DIV/DIVU are built only when EX_DIV_EN is defined; otherwise they act as NOP.
module ex_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  ex_operator,
    input  logic [2:0]  ex_category,
    input  logic [31:0] ex_operand1,
    input  logic [31:0] ex_operand2,
    input  logic [4:0]  ex_write_addr,
    input  logic        ex_write_enable,
    output logic [4:0]  mem_write_addr,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    output logic        stall_request
);
    localparam logic [2:0] CAT_LOGIC = 3'd1;
    localparam logic [2:0] CAT_SHIFT = 3'd2;
    localparam logic [2:0] CAT_MOVE  = 3'd3;
    localparam logic [2:0] CAT_ARITH = 3'd4;

    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_MFHI = 8'h10;
    localparam logic [7:0] OP_MTHI = 8'h11;
    localparam logic [7:0] OP_MFLO = 8'h12;
    localparam logic [7:0] OP_MTLO = 8'h13;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_div_wr;
    logic [31:0] w_div_hi;
    logic [31:0] w_div_lo;
    logic [4:0]  w_sh;

    assign mem_write_addr   = ex_write_addr;
    assign mem_write_enable = ex_write_enable;
    assign w_sh             = ex_operand1[4:0];

    always_comb begin
        mem_write_data = '0;
        case (ex_category)
            CAT_LOGIC: begin
                case (ex_operator)
                    OP_OR:   mem_write_data = ex_operand1 | ex_operand2;
                    OP_AND:  mem_write_data = ex_operand1 & ex_operand2;
                    OP_XOR:  mem_write_data = ex_operand1 ^ ex_operand2;
                    OP_NOR:  mem_write_data = ~(ex_operand1 | ex_operand2);
                    default: mem_write_data = '0;
                endcase
            end
            CAT_SHIFT: begin
                case (ex_operator)
                    OP_SLL:  mem_write_data = ex_operand2 << w_sh;
                    OP_SRL:  mem_write_data = ex_operand2 >> w_sh;
                    OP_SRA:  mem_write_data = $signed(ex_operand2) >>> w_sh;
                    default: mem_write_data = '0;
                endcase
            end
            CAT_ARITH: begin
                case (ex_operator)
                    OP_ADDU: mem_write_data = ex_operand1 + ex_operand2;
                    OP_SUBU: mem_write_data = ex_operand1 - ex_operand2;
                    OP_SLT:  mem_write_data = {31'd0, $signed(ex_operand1) < $signed(ex_operand2)};
                    default: mem_write_data = '0;
                endcase
            end
            CAT_MOVE: begin
                case (ex_operator)
                    OP_MFHI: mem_write_data = r_hi;
                    OP_MFLO: mem_write_data = r_lo;
                    default: mem_write_data = '0;
                endcase
            end
            default: mem_write_data = '0;
        endcase
    end

    // A finishing divide owns HI/LO; ID/EX is held during a divide so MTHI/MTLO cannot collide.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_div_wr) begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
        end else begin
            if (ex_operator == OP_MTHI) r_hi <= ex_operand1;
            if (ex_operator == OP_MTLO) r_lo <= ex_operand1;
        end
    end

`ifdef EX_DIV_EN
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DBZ, S_DONE} div_state_t;

    div_state_t  r_state;
    div_state_t  w_next;
    logic [5:0]  r_count;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        w_is_div;
    logic        w_signed;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [32:0] w_partial;
    logic [32:0] w_trial;

    assign w_is_div  = (ex_operator == OP_DIV) || (ex_operator == OP_DIVU);
    assign w_signed  = (ex_operator == OP_DIV);
    assign w_mag1    = (w_signed && ex_operand1[31]) ? -ex_operand1 : ex_operand1;
    assign w_mag2    = (w_signed && ex_operand2[31]) ? -ex_operand2 : ex_operand2;
    assign w_partial = {r_rem, r_quot[31]};
    assign w_trial   = w_partial - {1'b0, r_divisor};
    assign w_div_hi  = r_neg_r ? -r_rem : r_rem;
    assign w_div_lo  = r_neg_q ? -r_quot : r_quot;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_is_div) w_next = (ex_operand2 == '0) ? S_DBZ : S_RUN;
            S_RUN:   if (r_count == 6'd31) w_next = S_DONE;
            S_DBZ:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall_request = 1'b0;
        w_div_wr      = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE:  stall_request = w_is_div;
                S_RUN:   stall_request = 1'b1;
                S_DBZ:   stall_request = 1'b1;
                S_DONE:  w_div_wr      = 1'b1;
                default: stall_request = 1'b0;
            endcase
        end
    end

    // Divide by zero preloads the final HI/LO values so DONE writes them uncorrected.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_div) begin
                        r_count <= '0;
                        if (ex_operand2 == '0) begin
                            r_quot    <= '1;
                            r_rem     <= ex_operand1;
                            r_divisor <= '0;
                            r_neg_q   <= 1'b0;
                            r_neg_r   <= 1'b0;
                        end else begin
                            r_quot    <= w_mag1;
                            r_rem     <= '0;
                            r_divisor <= w_mag2;
                            r_neg_q   <= w_signed && (ex_operand1[31] ^ ex_operand2[31]);
                            r_neg_r   <= w_signed && ex_operand1[31];
                        end
                    end
                end
                S_RUN: begin
                    r_count <= r_count + 6'd1;
                    if (!w_trial[32]) begin
                        r_rem  <= w_trial[31:0];
                        r_quot <= {r_quot[30:0], 1'b1};
                    end else begin
                        r_rem  <= w_partial[31:0];
                        r_quot <= {r_quot[30:0], 1'b0};
                    end
                end
                default: begin
                end
            endcase
        end
    end
`else
    assign stall_request = 1'b0;
    assign w_div_wr      = 1'b0;
    assign w_div_hi      = '0;
    assign w_div_lo      = '0;
`endif

endmodule

// File: tb/tb_ex_unit.sv
// Self-checking bench for ex_unit: ALU vector table, HI/LO moves, divide sequences,
// reset abort and a randomized run against a reference model.
module tb_ex_unit;
  localparam logic [2:0] CAT_NOP   = 3'd0;
  localparam logic [2:0] CAT_LOGIC = 3'd1;
  localparam logic [2:0] CAT_SHIFT = 3'd2;
  localparam logic [2:0] CAT_MOVE  = 3'd3;
  localparam logic [2:0] CAT_ARITH = 3'd4;

  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MTHI = 8'h11;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_MTLO = 8'h13;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

`ifdef EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [7:0]  ex_operator;
  logic [2:0]  ex_category;
  logic [31:0] ex_operand1;
  logic [31:0] ex_operand2;
  logic [4:0]  ex_write_addr;
  logic        ex_write_enable;
  logic [4:0]  mem_write_addr;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic        stall_request;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] exp_q[$];

  ex_unit dut (
    .clock(clock), .reset(reset),
    .ex_operator(ex_operator), .ex_category(ex_category),
    .ex_operand1(ex_operand1), .ex_operand2(ex_operand2),
    .ex_write_addr(ex_write_addr), .ex_write_enable(ex_write_enable),
    .mem_write_addr(mem_write_addr), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .stall_request(stall_request)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] cat, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa, input logic we);
    @(posedge clock);
    #1;
    ex_operator = op; ex_category = cat; ex_operand1 = a; ex_operand2 = b;
    ex_write_addr = wa; ex_write_enable = we;
  endtask

  // reference model
  function automatic logic [2:0] cat_of(input logic [7:0] op);
    case (op)
      OP_OR, OP_AND, OP_XOR, OP_NOR: return CAT_LOGIC;
      OP_SLL, OP_SRL, OP_SRA:        return CAT_SHIFT;
      OP_ADDU, OP_SUBU, OP_SLT:      return CAT_ARITH;
      OP_MFHI, OP_MFLO:              return CAT_MOVE;
      default:                       return CAT_NOP;
    endcase
  endfunction

  function automatic logic [31:0] model_result(input logic [7:0] op, input logic [2:0] cat,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] r;
    int sh;
    sh = int'(a % 32);
    case (op)
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLL:  r = b << sh;
      OP_SRL:  r = b >> sh;
      OP_SRA:  r = 32'($signed(b) >>> sh);
      OP_ADDU: r = a + b;
      OP_SUBU: r = a - b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_MFHI: r = hi;
      OP_MFLO: r = lo;
      default: r = '0;
    endcase
    if (cat == CAT_NOP || cat != cat_of(op)) r = '0;
    return r;
  endfunction

  task automatic model_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (!DIV_EN) return;
    if (b == '0) begin
      m_hi = a; m_lo = '1;
    end else if (op == OP_DIVU) begin
      m_lo = a / b; m_hi = a % b;
    end else begin
      sa = $signed(a); sb = $signed(b);
      m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
    end
  endtask

  // present a divide held by upstream, count stall cycles, then read LO/HI back
  task automatic do_div(input string name, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int stalls;
    int exp_stalls;
    exp_stalls = !DIV_EN ? 0 : (b == '0 ? 2 : 33);
    drive(op, CAT_NOP, a, b, 5'd0, 1'b0);
    stalls = 0;
    @(negedge clock);
    while (stall_request === 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clock);
    end
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    check({name, "_done_data"}, mem_write_data, 32'd0);
    model_div(op, a, b);
    drive(OP_MFLO, CAT_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
    @(negedge clock);
    check({name, "_lo"}, mem_write_data, m_lo);
    check({name, "_no_restart"}, {31'd0, stall_request}, 32'd0);
    drive(OP_MFHI, CAT_MOVE, 32'd0, 32'd0, 5'd3, 1'b1);
    @(negedge clock);
    check({name, "_hi"}, mem_write_data, m_hi);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  cat;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];
  logic [7:0] rand_ops[14];

  initial begin
    vecs[0]  = '{OP_OR,   CAT_LOGIC, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF};
    vecs[1]  = '{OP_AND,  CAT_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00};
    vecs[2]  = '{OP_XOR,  CAT_LOGIC, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555};
    vecs[3]  = '{OP_NOR,  CAT_LOGIC, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    vecs[4]  = '{OP_SLL,  CAT_SHIFT, 32'h00000024, 32'h0000000F, 32'h000000F0};
    vecs[5]  = '{OP_SRL,  CAT_SHIFT, 32'h00000008, 32'h80000000, 32'h00800000};
    vecs[6]  = '{OP_SRA,  CAT_SHIFT, 32'h00000004, 32'h80000000, 32'hF8000000};
    vecs[7]  = '{OP_ADDU, CAT_ARITH, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    vecs[8]  = '{OP_SUBU, CAT_ARITH, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
    vecs[9]  = '{OP_SLT,  CAT_ARITH, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vecs[10] = '{OP_SLT,  CAT_ARITH, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    vecs[11] = '{OP_OR,   CAT_NOP,   32'h12345678, 32'h0000FFFF, 32'h00000000};
    vecs[12] = '{8'hEE,   CAT_LOGIC, 32'h12345678, 32'h0000FFFF, 32'h00000000};
    vecs[13] = '{OP_ADDU, CAT_LOGIC, 32'h00000001, 32'h00000001, 32'h00000000};
    rand_ops = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_ADDU,
                 OP_SUBU, OP_SLT, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};

    // reset with a divide presented: stall must stay low
    reset = 1'b1;
    ex_operator = OP_DIVU; ex_category = CAT_NOP;
    ex_operand1 = 32'd100; ex_operand2 = 32'd7;
    ex_write_addr = 5'd0; ex_write_enable = 1'b0;
    @(negedge clock);
    check("reset_stall", {31'd0, stall_request}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    drive(OP_MFHI, CAT_MOVE, 32'd0, 32'd0, 5'd1, 1'b1);
    @(negedge clock);
    check("reset_hi", mem_write_data, 32'd0);
    drive(OP_MFLO, CAT_MOVE, 32'd0, 32'd0, 5'd1, 1'b1);
    @(negedge clock);
    check("reset_lo", mem_write_data, 32'd0);

    // vector table
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].cat, vecs[i].a, vecs[i].b, 5'(i + 3), i[0]);
      @(negedge clock);
      check($sformatf("vec%0d_data", i), mem_write_data, vecs[i].exp);
      check($sformatf("vec%0d_addr", i), {27'd0, mem_write_addr}, 32'(i + 3));
      check($sformatf("vec%0d_we", i), {31'd0, mem_write_enable}, {31'd0, i[0]});
      check($sformatf("vec%0d_stall", i), {31'd0, stall_request}, 32'd0);
    end

    // MTHI/MTLO visible next cycle
    drive(OP_MTHI, CAT_NOP, 32'h12345678, 32'd0, 5'd0, 1'b0);
    drive(OP_MFHI, CAT_MOVE, 32'd0, 32'd0, 5'd4, 1'b1);
    @(negedge clock);
    check("mthi_mfhi", mem_write_data, 32'h12345678);
    drive(OP_MTLO, CAT_NOP, 32'h9ABCDEF0, 32'd0, 5'd0, 1'b0);
    drive(OP_MFLO, CAT_MOVE, 32'd0, 32'd0, 5'd4, 1'b1);
    @(negedge clock);
    check("mtlo_mflo", mem_write_data, 32'h9ABCDEF0);
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

    // directed divides
    do_div("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    do_div("div_m100_7", OP_DIV, 32'hFFFFFF9C, 32'd7);
    do_div("div_5_0", OP_DIV, 32'd5, 32'd0);
    do_div("div_100_m7", OP_DIV, 32'd100, 32'hFFFFFFF9);
    do_div("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h00000003);

    // reset mid-divide aborts with no HI/LO write
    drive(OP_MTHI, CAT_NOP, 32'hCAFEF00D, 32'd0, 5'd0, 1'b0);
    drive(OP_MTLO, CAT_NOP, 32'hBEEF0001, 32'd0, 5'd0, 1'b0);
    drive(OP_DIVU, CAT_NOP, 32'd100, 32'd7, 5'd0, 1'b0);
    repeat (11) @(negedge clock);
    check("abort_run_stall", {31'd0, stall_request}, DIV_EN ? 32'd1 : 32'd0);
    reset = 1'b1;
    #1;
    check("abort_reset_stall", {31'd0, stall_request}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    ex_operator = OP_MFHI; ex_category = CAT_MOVE;
    m_hi = '0; m_lo = '0;
    @(negedge clock);
    check("abort_stall_after", {31'd0, stall_request}, 32'd0);
    check("abort_hi", mem_write_data, m_hi);
    drive(OP_MFLO, CAT_MOVE, 32'd0, 32'd0, 5'd1, 1'b1);
    @(negedge clock);
    check("abort_lo", mem_write_data, m_lo);
    drive(OP_ADDU, CAT_ARITH, 32'd1, 32'd2, 5'd1, 1'b1);
    @(negedge clock);
    check("abort_idle_stall", {31'd0, stall_request}, 32'd0);

    // randomized run with scoreboard
    for (int n = 0; n < 200; n++) begin
      logic [7:0] op;
      logic [31:0] a, b;
      logic [4:0] wa;
      logic we;
      if ($urandom_range(0, 19) == 0) begin
        a = $urandom();
        if ($urandom_range(0, 3) == 0) b = '0;
        else if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(1, 50));
        else b = $urandom();
        do_div($sformatf("rnd%0d_div", n), $urandom_range(0, 1) ? OP_DIV : OP_DIVU, a, b);
      end else begin
        op = rand_ops[$urandom_range(0, 13)];
        a = $urandom(); b = $urandom();
        wa = 5'($urandom_range(0, 31)); we = 1'($urandom_range(0, 1));
        drive(op, cat_of(op), a, b, wa, we);
        exp_q.push_back(model_result(op, cat_of(op), a, b, m_hi, m_lo));
        if (op == OP_MTHI) m_hi = a;
        if (op == OP_MTLO) m_lo = a;
        @(negedge clock);
        check($sformatf("rnd%0d_data", n), mem_write_data, exp_q.pop_front());
        check($sformatf("rnd%0d_pass", n), {26'd0, mem_write_enable, mem_write_addr}, {26'd0, we, wa});
        check($sformatf("rnd%0d_stall", n), {31'd0, stall_request}, 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
